// File: rtl/jtkcpu_busresp.sv
// JTKCPU bus responder: address decode, wait-state insertion and dtack for an internal
// RAM plus a 4-byte interrupt-controller register window.
module jtkcpu_busresp #(
  parameter int unsigned RAM_AW   = 11,
  parameter logic [23:0] RAM_BASE = 24'h000000,
  parameter logic [23:0] REG_BASE = 24'h00FF00,
  parameter int unsigned WAIT_RAM = 1,
  parameter int unsigned WAIT_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [23:0] addr,
  input  logic [7:0]  cpu_dout,
  input  logic        we,
  input  logic        as,
  output logic [7:0]  din,
  output logic        dtack,
  input  logic        ev_irq,
  input  logic        ev_firq,
  input  logic        ev_nmi,
  output logic        irq,
  output logic        firq,
  output logic        nmi
);

  localparam int unsigned RAM_SIZE = 1 << RAM_AW;
  localparam int unsigned CW       = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [23:0]   lat_addr;
  logic          lat_we;
  logic [7:0]    lat_dout;
  logic [7:0]    din_nx;
  logic          dtack_nx;
  logic          latch_c;
  logic          access_c;
  logic [7:0]    rd_c;
  logic          ram_we_c;
  logic          reg_we_c;
  logic [2:0]    rise_c;
  logic [2:0]    ack_clr_c;

  logic [7:0]    mem [RAM_SIZE];
  logic [2:0]    pend;      // {nmi, firq, irq}
  logic [2:0]    ev_prev;
  logic [1:0]    mask;

  // The register window takes priority over RAM when the two overlap
  function automatic logic reg_hit(input logic [23:0] a);
    return a[23:2] == REG_BASE[23:2];
  endfunction

  function automatic logic ram_hit(input logic [23:0] a);
    return !reg_hit(a) && (a[23:RAM_AW] == RAM_BASE[23:RAM_AW]);
  endfunction

  // Read data selected from the latched address
  always_comb begin
    rd_c = 8'hFF;
    if (reg_hit(lat_addr)) begin
      case (lat_addr[1:0])
        2'd0:    rd_c = {5'b0, pend};
        2'd1:    rd_c = {6'b0, mask};
        default: rd_c = 8'h00;
      endcase
    end else if (ram_hit(lat_addr)) begin
      rd_c = mem[lat_addr[RAM_AW-1:0]];
    end
  end

  // Bus FSM next-state and registered-output values
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    din_nx   = din;
    dtack_nx = dtack;
    latch_c  = 1'b0;
    access_c = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          if (as) begin
            state_nx = WAIT;
            latch_c  = 1'b1;
            cnt_nx   = ram_hit(addr) ? CW'(WAIT_RAM) : CW'(WAIT_REG);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt_nx = cnt - CW'(1);
          end else begin
            state_nx = ACK;
            access_c = 1'b1;
            dtack_nx = 1'b1;
            if (!lat_we) din_nx = rd_c;
          end
        end
        ACK: begin
          if (!as) begin
            state_nx = IDLE;
            dtack_nx = 1'b0;
            din_nx   = 8'hFF;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign ram_we_c  = access_c && lat_we && ram_hit(lat_addr) && !rst;
  assign reg_we_c  = access_c && lat_we && reg_hit(lat_addr);
  assign rise_c    = {ev_nmi, ev_firq, ev_irq} & ~ev_prev;
  assign ack_clr_c = (reg_we_c && lat_addr[1:0] == 2'd2) ? lat_dout[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      din      <= 8'hFF;
      dtack    <= 1'b0;
      lat_addr <= '0;
      lat_we   <= 1'b0;
      lat_dout <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      din   <= din_nx;
      dtack <= dtack_nx;
      if (latch_c) begin
        lat_addr <= addr;
        lat_we   <= we;
        lat_dout <= cpu_dout;
      end
    end
  end

  // RAM storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[lat_addr[RAM_AW-1:0]] <= lat_dout;
  end

  // Interrupt controller runs every clk; a new edge beats an ACK clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      ev_prev <= '0;
      mask    <= '0;
      irq     <= 1'b0;
      firq    <= 1'b0;
      nmi     <= 1'b0;
    end else begin
      ev_prev <= {ev_nmi, ev_firq, ev_irq};
      pend    <= (pend & ~ack_clr_c) | rise_c;
      if (reg_we_c && lat_addr[1:0] == 2'd1) mask <= lat_dout[1:0];
      irq  <= pend[0] & mask[0];
      firq <= pend[1] & mask[1];
      nmi  <= pend[2];
    end
  end

endmodule
